// File: rtl/bitmatrix_gen_if.sv
// Handshake bundle between the coefficient store (master) and the
// bitmatrix generator (slave): one element in, one W x W matrix out.
interface bitmatrix_gen_if #(
  parameter int W    = 3,
  parameter int ID_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_elem;
  logic [ID_W-1:0] in_id;
  logic            out_valid;
  logic            out_ready;
  logic [W*W-1:0]  mat_rows;
  logic [ID_W-1:0] out_id;
  logic            busy;

  modport master (
    output in_valid, in_elem, in_id, out_ready,
    input  in_ready, out_valid, mat_rows, out_id, busy
  );

  modport slave (
    input  in_valid, in_elem, in_id, out_ready,
    output in_ready, out_valid, mat_rows, out_id, busy
  );
endinterface

// File: rtl/bitmatrix_gen.sv
// Builds the GF(2^W) multiply bitmatrix of one element, one column per cycle,
// by repeated multiply-by-x modulo POLY; holds the result until accepted.
module bitmatrix_gen #(
  parameter int         W    = 3,
  parameter logic [W:0] POLY = 4'b1011,
  parameter int         ID_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bitmatrix_gen_if.slave  bus
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t            state_q;
  logic [W-1:0]      acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [W*W-1:0]    mat_q, mat_d;
  logic [ID_W-1:0]   id_q;
  logic              out_valid_q;

  // Multiply by x and reduce; the bit shifted out of the top folds back in via POLY.
  function automatic logic [W-1:0] xtime(input logic [W-1:0] a);
    return {a[W-2:0], 1'b0} ^ (a[W-1] ? POLY[W-1:0] : '0);
  endfunction

  // Column cnt of the matrix is e*x^cnt, i.e. bit i of acc lands in row i.
  always_comb begin
    // NOTE: default assignment first so every path drives mat_d and no latch is inferred.
    mat_d = mat_q;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if (cnt_q == CNT_W'(j)) mat_d[i*W + j] = acc_q[i];
      end
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      mat_q       <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            acc_q   <= bus.in_elem;
            id_q    <= bus.in_id;
            cnt_q   <= '0;
            mat_q   <= '0;
            state_q <= GEN;
          end
        end
        GEN: begin
          mat_q <= mat_d;
          acc_q <= xtime(acc_q);
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(W-1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here; the next accept waits for IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.mat_rows  = mat_q;
  assign bus.out_id    = id_q;

endmodule
